pcie_tx_arbiter: RTL

- Shares the single 32-bit PCIe TX AXI-stream (s_axis_tx_*) between two TLP sources: src0 (completion engine) and src1 (DMA write engine).
- Arbitrates packet-atomically, round-robin.
- Honours core buffer availability (tx_buf_av) and the core's config-TLP request (tx_cfg_req / tx_cfg_gnt).
- Drains in-flight packets when the link drops.
- Sits between the user TLP engines and the PCIe AXI bridge.

---
 rtl/pcie_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the PCIe TX AXI-stream between the
// completion engine (src0), the DMA write engine (src1) and core config TLPs.
module pcie_tx_arbiter #(
    parameter logic [5:0] MIN_BUF_AV   = 6'd2,
    parameter int         CFG_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_user_lnk_up,
    input  logic [31:0] i_src0_tdata,
    input  logic [3:0]  i_src0_tkeep,
    input  logic [3:0]  i_src0_tuser,
    input  logic        i_src0_tlast,
    input  logic        i_src0_tvalid,
    output logic        o_src0_tready,
    input  logic [31:0] i_src1_tdata,
    input  logic [3:0]  i_src1_tkeep,
    input  logic [3:0]  i_src1_tuser,
    input  logic        i_src1_tlast,
    input  logic        i_src1_tvalid,
    output logic        o_src1_tready,
    output logic [31:0] o_tx_tdata,
    output logic [3:0]  o_tx_tkeep,
    output logic [3:0]  o_tx_tuser,
    output logic        o_tx_tlast,
    output logic        o_tx_tvalid,
    input  logic        i_tx_tready,
    input  logic [5:0]  i_tx_buf_av,
    input  logic        i_tx_cfg_req,
    output logic        o_tx_cfg_gnt,
    output logic [1:0]  o_active_src,
    output logic [15:0] o_src0_pkt_count,
    output logic [15:0] o_src1_pkt_count,
    output logic [15:0] o_drop_count
);

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic [3:0]  tuser;
        logic        tlast;
    } beat_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SRC0   = 3'd1,
        SRC1   = 3'd2,
        CFG    = 3'd3,
        FLUSH0 = 3'd4,
        FLUSH1 = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        last_src_q, last_src_d;
    logic [15:0] src0_cnt_q, src1_cnt_q, drop_cnt_q;

    beat_t [1:0] src_beat;
    beat_t       tx_beat;
    logic  [1:0] src_vld;
    logic  [1:0] src_rdy;
    logic  [1:0] pkt_done;
    logic        pkt_drop;
    logic        any_vld;
    logic        sel;
    logic        pick;

    assign src_beat[0] = {i_src0_tdata, i_src0_tkeep, i_src0_tuser, i_src0_tlast};
    assign src_beat[1] = {i_src1_tdata, i_src1_tkeep, i_src1_tuser, i_src1_tlast};
    assign src_vld     = {i_src1_tvalid, i_src0_tvalid};
    assign any_vld     = |src_vld;

    always_comb begin
        state_d      = state_q;
        last_src_d   = last_src_q;
        tx_beat      = '0;
        o_tx_tvalid  = 1'b0;
        src_rdy      = 2'b00;
        o_tx_cfg_gnt = 1'b0;
        o_active_src = 2'b00;
        pkt_done     = 2'b00;
        pkt_drop     = 1'b0;
        pick         = 1'b0;
        sel          = (state_q == SRC1) || (state_q == FLUSH1);

        case (state_q)
            IDLE: begin
                if (i_tx_cfg_req && ((CFG_PRIORITY != 0) || !any_vld)) begin
                    state_d = CFG;
                end else if (i_user_lnk_up && (i_tx_buf_av >= MIN_BUF_AV) && any_vld) begin
                    // On a tie the source not served last wins.
                    pick       = (&src_vld) ? ~last_src_q : src_vld[1];
                    last_src_d = pick;
                    state_d    = pick ? SRC1 : SRC0;
                end
            end
            SRC0, SRC1: begin
                tx_beat      = src_beat[sel];
                o_tx_tvalid  = src_vld[sel];
                src_rdy[sel] = i_tx_tready;
                o_active_src = sel ? 2'b10 : 2'b01;
                // A completed packet takes precedence over a simultaneous link drop.
                if (src_vld[sel] && i_tx_tready && src_beat[sel].tlast) begin
                    pkt_done[sel] = 1'b1;
                    state_d       = IDLE;
                end else if (!i_user_lnk_up) begin
                    state_d = sel ? FLUSH1 : FLUSH0;
                end
            end
            FLUSH0, FLUSH1: begin
                src_rdy[sel] = 1'b1;
                if (src_vld[sel] && src_beat[sel].tlast) begin
                    pkt_drop = 1'b1;
                    state_d  = IDLE;
                end
            end
            CFG: begin
                o_tx_cfg_gnt = 1'b1;
                o_active_src = 2'b11;
                if (!i_tx_cfg_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_src_q <= 1'b1;
            src0_cnt_q <= '0;
            src1_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            if (pkt_done[0]) src0_cnt_q <= src0_cnt_q + 16'd1;
            if (pkt_done[1]) src1_cnt_q <= src1_cnt_q + 16'd1;
            if (pkt_drop)    drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign o_tx_tdata       = tx_beat.tdata;
    assign o_tx_tkeep       = tx_beat.tkeep;
    assign o_tx_tuser       = tx_beat.tuser;
    assign o_tx_tlast       = tx_beat.tlast;
    assign o_src0_tready    = src_rdy[0];
    assign o_src1_tready    = src_rdy[1];
    assign o_src0_pkt_count = src0_cnt_q;
    assign o_src1_pkt_count = src1_cnt_q;
    assign o_drop_count     = drop_cnt_q;

endmodule
